// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of a byte-addressed data memory.
// Port 0 is the core load/store unit and port 1 is the debug/DMA master.
// One request is granted at a time, and the memory is driven from a registered command.
// Read data returns two cycles after accept.
// Misaligned and out-of-range accesses complete with an error and never touch memory.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 i_req_valid,
    output logic [1:0]                 o_req_ready,
    input  logic [1:0]                 i_req_we,
    input  logic [1:0][ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] i_req_wdata,
    input  logic [1:0][1:0]            i_req_size,
    input  logic [1:0]                 i_req_sign,
    output logic [1:0]                 o_rsp_valid,
    output logic [DATA_WIDTH-1:0]      o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic                       o_mem_we,
    output logic [ADDR_WIDTH-1:0]      o_mem_addr,
    output logic [DATA_WIDTH-1:0]      o_mem_wdata,
    output logic [1:0]                 o_mem_size,
    output logic                       o_mem_sign,
    input  logic [DATA_WIDTH-1:0]      i_mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // One past the last legal byte address; the +1 bit keeps addr+bytes from wrapping.
    localparam logic [ADDR_WIDTH:0] LP_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    // Alignment and range check; size 11 is treated as a word.
    function automatic logic f_access_err(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [1:0]            size);
        logic [ADDR_WIDTH:0] end_addr;
        logic                misalign;
        case (size)
            SZ_B: begin
                misalign = 1'b0;
                end_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(1);
            end
            SZ_H: begin
                misalign = addr[0];
                end_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(2);
            end
            default: begin
                misalign = |addr[1:0];
                end_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(4);
            end
        endcase
        return misalign || (end_addr > LP_LIMIT);
    endfunction

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_cmd_port;
    logic                  r_cmd_we;
    logic                  r_cmd_err;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [1:0]            r_mem_size;
    logic                  r_mem_sign;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_port;
    logic                  w_sel_err;

    // Combinational grant: only while not accessing, and only one port at a time.
    always_comb begin
        w_grant = 2'b00;
        if (r_state != S_ACCESS) begin
            if (&i_req_valid) begin
                if (RR_EN && !r_last_grant) begin
                    w_grant = 2'b10;
                end else begin
                    w_grant = 2'b01;
                end
            end else begin
                w_grant = i_req_valid;
            end
        end
    end

    assign w_accept  = |w_grant;
    assign w_port    = w_grant[1];
    assign w_sel_err = f_access_err(i_req_addr[w_port], i_req_size[w_port]);

    // Sequencer FSM: accept -> ACCESS (memory cycle) -> RESP (response pulse, may re-accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cmd_port   <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_err    <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 2'b00;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_state      <= S_ACCESS;
                        r_last_grant <= w_port;
                        r_cmd_port   <= w_port;
                        r_cmd_we     <= i_req_we[w_port];
                        r_cmd_err    <= w_sel_err;
                        r_mem_we     <= i_req_we[w_port] & ~w_sel_err;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= r_cmd_port ? 2'b10 : 2'b01;
                    r_rsp_err   <= r_cmd_err;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Command/response datapath: memory command latched on accept, read data captured in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= SZ_W;
            r_mem_sign  <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_mem_addr  <= i_req_addr[w_port];
                r_mem_wdata <= i_req_wdata[w_port];
                r_mem_size  <= i_req_size[w_port];
                r_mem_sign  <= i_req_sign[w_port];
            end
            if (r_state == S_ACCESS) begin
                r_rsp_rdata <= (r_cmd_err || r_cmd_we) ? '0 : i_mem_rdata;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_size  = r_mem_size;
    assign o_mem_sign  = r_mem_sign;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 4 KB byte memory model behind the round-robin
// instance, plus a fixed-priority instance on the same request inputs with a stub memory.
module tb_dmem_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_sign;

    logic [1:0]       req_ready, rsp_valid;
    logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic             rsp_err, mem_we, mem_sign;
    logic [1:0]       mem_size;

    logic [1:0]       fp_req_ready, fp_rsp_valid, fp_mem_size;
    logic [31:0]      fp_rsp_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
    logic             fp_rsp_err, fp_mem_we, fp_mem_sign;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];
    logic       loaded = 1'b0;
    int         we_cnt = 0;
    logic [7:0] b0, b1, b2, b3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
        .i_req_sign(req_sign), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_size(mem_size), .o_mem_sign(mem_sign),
        .i_mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(fp_req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
        .i_req_sign(req_sign), .o_rsp_valid(fp_rsp_valid), .o_rsp_rdata(fp_rsp_rdata),
        .o_rsp_err(fp_rsp_err), .o_mem_we(fp_mem_we), .o_mem_addr(fp_mem_addr),
        .o_mem_wdata(fp_mem_wdata), .o_mem_size(fp_mem_size), .o_mem_sign(fp_mem_sign),
        .i_mem_rdata(fp_mem_rdata)
    );

    // Stub memory for the fixed-priority instance: data identifies the address read.
    assign fp_mem_rdata = {16'hF0F0, fp_mem_addr[15:0]};

    // Memory model write port and one-time preload.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h021] <= 8'h80;
            mem[12'h005] <= 8'h55; mem[12'h006] <= 8'h66; mem[12'h007] <= 8'h77;
            mem[12'h008] <= 8'h88; mem[12'h009] <= 8'h99;
            mem[12'h100] <= 8'h22; mem[12'h101] <= 8'h22; mem[12'h102] <= 8'h11; mem[12'h103] <= 8'h11;
            mem[12'h104] <= 8'h44; mem[12'h105] <= 8'h44; mem[12'h106] <= 8'h33; mem[12'h107] <= 8'h33;
            mem[12'hFFC] <= 8'h0D; mem[12'hFFD] <= 8'hF0; mem[12'hFFE] <= 8'hFE; mem[12'hFFF] <= 8'hCA;
            mem[12'h040] <= 8'h04; mem[12'h041] <= 8'h03; mem[12'h042] <= 8'h02; mem[12'h043] <= 8'h01;
            loaded <= 1'b1;
        end
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            case (mem_size)
                2'b00: mem[mem_addr[11:0]] <= mem_wdata[7:0];
                2'b01: begin
                    mem[mem_addr[11:0]]         <= mem_wdata[7:0];
                    mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                end
                default: begin
                    mem[mem_addr[11:0]]         <= mem_wdata[7:0];
                    mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                    mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                    mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
                end
            endcase
        end
    end

    // Memory model combinational read with size/sign extension; bytes past 4 KB read as 0.
    always_comb begin
        b0 = (mem_addr < 32'd4096) ? mem[mem_addr[11:0]] : 8'h00;
        b1 = (mem_addr < 32'd4095) ? mem[mem_addr[11:0] + 12'd1] : 8'h00;
        b2 = (mem_addr < 32'd4094) ? mem[mem_addr[11:0] + 12'd2] : 8'h00;
        b3 = (mem_addr < 32'd4093) ? mem[mem_addr[11:0] + 12'd3] : 8'h00;
        case (mem_size)
            2'b00:   mem_rdata = mem_sign ? {{24{b0[7]}}, b0} : {24'h0, b0};
            2'b01:   mem_rdata = mem_sign ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction from an idle DUT; entered and left at posedge+1.
    task automatic access(input string tag, input logic [1:0] vld, input int exp_port,
                          input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sign,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic [1:0] exp_g;
        int         we0;
        exp_g = (exp_port == 0) ? 2'b01 : 2'b10;
        we0   = we_cnt;
        req_we    = {we, we};
        req_addr  = {addr, addr};
        req_wdata = {wdata, wdata};
        req_size  = {size, size};
        req_sign  = {sign, sign};
        req_valid = vld;
        @(negedge clk);
        chk({tag, "_ready"}, {30'h0, req_ready}, {30'h0, exp_g});
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, "_memwe"}, {31'h0, mem_we}, {31'h0, we & ~exp_err});
        chk({tag, "_memaddr"}, mem_addr, addr);
        chk({tag, "_memsize"}, {30'h0, mem_size}, {30'h0, size});
        chk({tag, "_memsign"}, {31'h0, mem_sign}, {31'h0, sign});
        if (we) chk({tag, "_memwdata"}, mem_wdata, wdata);
        chk({tag, "_ready_acc"}, {30'h0, req_ready}, 32'h0);
        chk({tag, "_rspv_acc"}, {30'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_rspv"}, {30'h0, rsp_valid}, {30'h0, exp_g});
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        chk({tag, "_wecnt"}, we_cnt - we0, {31'h0, we & ~exp_err});
        chk({tag, "_memwe_rsp"}, {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        req_size = '0; req_sign = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_rspv", {30'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_memwe", {31'h0, mem_we}, 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_memwdata", mem_wdata, 32'h0);
        chk("rst_memsize", {30'h0, mem_size}, 32'h2);
        chk("rst_memsign", {31'h0, mem_sign}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word write then read-back on port 0.
        access("wr10", 2'b01, 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        chk("wr10_mem", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]}, 32'hDEADBEEF);
        access("rd10", 2'b01, 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte reads with and without sign extension.
        access("rdsb", 2'b10, 1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
        access("rdub", 2'b10, 1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0);

        // Misaligned accesses.
        access("wrh5", 2'b01, 0, 1'b1, 32'h5, 32'h0000AAAA, 2'b01, 1'b0, 32'h0, 1'b1);
        chk("wrh5_mem", {16'h0, mem[12'h006], mem[12'h005]}, 32'h00006655);
        access("rdw6", 2'b10, 1, 1'b0, 32'h6, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);

        // Range checks at the top of memory.
        access("rdwffc", 2'b01, 0, 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
        access("rdwffe", 2'b01, 0, 1'b0, 32'hFFE, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        access("rdb1000", 2'b01, 0, 1'b0, 32'h1000, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);

        // Continuous contention from both ports after a fresh reset.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_we = 2'b00; req_size = {2'b10, 2'b10}; req_sign = 2'b00;
        req_addr = {32'h104, 32'h100};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr_ready%0d", k), {30'h0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("fp_ready%0d", k), {30'h0, fp_req_ready}, 32'h1);
            if (k > 0) begin
                chk($sformatf("rr_rspv%0d", k - 1), {30'h0, rsp_valid}, ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("rr_rdata%0d", k - 1), rsp_rdata, ((k - 1) % 2 == 0) ? 32'h11112222 : 32'h33334444);
                chk($sformatf("fp_rspv%0d", k - 1), {30'h0, fp_rsp_valid}, 32'h1);
                chk($sformatf("fp_rdata%0d", k - 1), fp_rsp_rdata, 32'hF0F00100);
            end
            @(posedge clk); #1;
            if (k == 5) req_valid = 2'b00;
            @(negedge clk);
            chk($sformatf("rr_ready_acc%0d", k), {30'h0, req_ready}, 32'h0);
            chk($sformatf("fp_ready_acc%0d", k), {30'h0, fp_req_ready}, 32'h0);
            chk($sformatf("rr_memaddr%0d", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h104);
            chk($sformatf("rr_rspv_acc%0d", k), {30'h0, rsp_valid}, 32'h0);
            chk($sformatf("fp_memwe%0d", k), {31'h0, fp_mem_we}, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rr_rspv5", {30'h0, rsp_valid}, 32'h2);
        chk("rr_rdata5", rsp_rdata, 32'h33334444);
        chk("fp_rspv5", {30'h0, fp_rsp_valid}, 32'h1);
        chk("fp_err5", {31'h0, fp_rsp_err}, 32'h0);
        @(posedge clk); #1;

        // Reset asserted during the ACCESS cycle of a write.
        req_we = 2'b01; req_addr = {32'h0, 32'h40}; req_wdata = {32'h0, 32'h99887766};
        req_size = {2'b10, 2'b10};
        req_valid = 2'b01;
        we_cnt = we_cnt;
        @(negedge clk);
        chk("rsta_ready", {30'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rsta_memwe_pre", {31'h0, mem_we}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rsta_memwe_rst", {31'h0, mem_we}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rsta_rspv%0d", c), {30'h0, rsp_valid}, 32'h0);
            chk($sformatf("rsta_memwe%0d", c), {31'h0, mem_we}, 32'h0);
        end
        @(posedge clk); #1;
        chk("rsta_mem40", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]}, 32'h01020304);
        access("rst_tie", 2'b11, 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        access("rst_tie2", 2'b11, 1, 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the byte-addressed data memory (4 KB, combinational read, synchronous write).
- Port 0 is the core load/store unit; port 1 is the debug/DMA master.
- Grants one request at a time, drives the memory port from a registered command and returns read data with a fixed-latency response.
- Misaligned and out-of-range accesses are rejected without touching memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width.
- MEM_BYTES, 4096, memory size in bytes; used for the range check.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_we  in  2  per-port write enable
- req_addr  in  2xADDR_WIDTH  per-port byte address
- req_wdata  in  2xDATA_WIDTH  per-port write data
- req_size  in  2x mem_size_t  per-port size: 00 byte, 01 half, 10 word
- req_sign  in  2  per-port sign-extend select for reads
- rsp_valid  out  2  per-port one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  response read data, shared by both ports
- rsp_err  out  1  response error flag, qualified by rsp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_size  out  mem_size_t  memory size
- mem_sign  out  1  memory sign select
- mem_rdata  in  DATA_WIDTH  memory read data (combinational)

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_size=MEM_SIZE_W, mem_sign=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
  - Arbitration is enabled in IDLE and RESP.
  - In ACCESS, req_ready=00.
- Arbitration is combinational on req_valid.
  - Only the winning port sees req_ready=1; req_ready may depend on req_valid.
  - Only one port is granted per accept.
  - RR_EN=1: when both ports are valid, grant the port not equal to last_grant. last_grant updates on every accept.
  - RR_EN=0: port 0 always wins.
- Accept cycle N (valid && ready):
  - Latch we, addr, wdata, size, sign and port id into the command register.
  - Compute err: H with addr[0]=1; W with addr[1:0]!=0; or addr+bytes > MEM_BYTES. bytes is 1, 2 or 4; size 11 is treated as W.
  - Next state ACCESS.
- ACCESS, cycle N+1:
  - mem_* driven from the command register.
  - mem_we=1 only if the command is a write and err=0; exactly one cycle.
  - For reads, capture mem_rdata at the end of the cycle.
  - If err=1: mem_we=0 and the captured data is forced to 0.
  - Next state RESP.
- RESP, cycle N+2:
  - rsp_valid[port]=1 for exactly one cycle.
  - rsp_rdata = captured data (0 for writes), with rsp_err.
  - A new request may be accepted in this same cycle → ACCESS; otherwise → IDLE.
- Throughput: one access per 2 cycles under continuous load. Read latency is accept + 2 cycles.
- mem_addr, mem_wdata, mem_size and mem_sign hold their last value when idle; mem_we is 0 outside ACCESS.
- No response backpressure: requesters must accept the rsp_valid pulse.
- Reset mid-operation, in any state:
  - Immediately return to IDLE.
  - Any in-flight write is not performed if reset is asserted before the ACCESS clock edge.
  - The pending response is dropped; no rsp_valid after reset release.
- A request whose req_valid drops before acceptance is not latched. req_valid is expected to stay high until accepted; this is not checked.

Test Plan:
- Port 0 word write: addr=0x10, wdata=0xDEADBEEF; then word read at 0x10 → mem_we pulses once in N+1; read rsp_valid[0] at accept+2 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both ports valid every cycle, RR_EN=1, 6 requests → grants alternate 0,1,0,1,0,1; accepts spaced 2 cycles apart; each response goes to the correct port. Repeat with RR_EN=0 → port 1 starves while port 0 remains valid.
- Signed byte read: memory byte 0x80 at addr 0x21, sign=1 → rsp_rdata=0xFFFFFF80. Same read with sign=0 → 0x00000080.
- Misaligned H write at addr 0x5 and W read at 0x6 → mem_we stays 0; rsp_err=1; rsp_rdata=0; memory contents unchanged.
- Range: W read at 0xFFC → ok. W read at 0xFFE and B read at 0x1000 → rsp_err=1.
- Assert rst_n low in ACCESS of a write to 0x40 → no memory update at 0x40; no rsp_valid after release; next request is served normally with port 0 winning the tie.
